// File: rtl/l_class_oc_fifoarb2.sv
// rtl/l_class_oc_fifoarb2.sv - two-requester round-robin arbiter feeding a one-entry tagged holding slot
module l_class_oc_fifoarb2 #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in0__ENA,
  input  logic [WIDTH-1:0] in0_v,
  output logic             in0__RDY,
  input  logic             in1__ENA,
  input  logic [WIDTH-1:0] in1_v,
  output logic             in1__RDY,
  input  logic             deq__ENA,
  output logic             deq__RDY,
  output logic [WIDTH-1:0] first,
  output logic             first_src,
  output logic             first__RDY,
  output logic [CNTW-1:0]  cnt0,
  output logic [CNTW-1:0]  cnt1
);

  logic [WIDTH-1:0] r_element;
  logic             r_src;
  logic             r_full;
  logic             r_prio;
  logic [CNTW-1:0]  r_cnt0;
  logic [CNTW-1:0]  r_cnt1;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_deq;

  // nRST gates the grants so no requester sees ready while reset is held.
  assign w_grant0 = nRST && !r_full && in0__ENA && (!in1__ENA || (r_prio == 1'b0));
  assign w_grant1 = nRST && !r_full && in1__ENA && (!in0__ENA || (r_prio == 1'b1));
  assign w_deq    = deq__ENA && r_full;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_element <= '0;
      r_src     <= 1'b0;
      r_full    <= 1'b0;
      r_prio    <= 1'b0;
      r_cnt0    <= '0;
      r_cnt1    <= '0;
    end else begin
      if (w_grant0) begin
        r_element <= in0_v;
        r_src     <= 1'b0;
        r_full    <= 1'b1;
        r_prio    <= 1'b1;
        if (r_cnt0 != '1) begin
          r_cnt0 <= r_cnt0 + CNTW'(1);
        end
      end else if (w_grant1) begin
        r_element <= in1_v;
        r_src     <= 1'b1;
        r_full    <= 1'b1;
        r_prio    <= 1'b0;
        if (r_cnt1 != '1) begin
          r_cnt1 <= r_cnt1 + CNTW'(1);
        end
      end else if (w_deq) begin
        // element and src stay as they were; only the valid flag drops.
        r_full <= 1'b0;
      end
    end
  end

  assign in0__RDY   = w_grant0;
  assign in1__RDY   = w_grant1;
  assign deq__RDY   = r_full;
  assign first__RDY = r_full;
  assign first      = r_element;
  assign first_src  = r_src;
  assign cnt0       = r_cnt0;
  assign cnt1       = r_cnt1;

endmodule

// File: tb/tb_l_class_oc_fifoarb2.sv
// tb/tb_l_class_oc_fifoarb2.sv - directed and random checks of the arbiter against a slot/fairness model
module tb_l_class_oc_fifoarb2;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        in0__ENA = 1'b0, in1__ENA = 1'b0, deq__ENA = 1'b0;
  logic [31:0] in0_v = '0, in1_v = '0;
  logic        in0__RDY, in1__RDY, deq__RDY, first_src, first__RDY;
  logic [31:0] first;
  logic [15:0] cnt0, cnt1;
  logic        s_in0_rdy, s_in1_rdy, s_deq_rdy, s_first_src, s_first_rdy;
  logic [31:0] s_first;
  logic [1:0]  s_cnt0, s_cnt1;

  always #5 CLK = ~CLK;

  l_class_oc_fifoarb2 #(.WIDTH(32), .CNTW(16)) u_dut (
    .CLK(CLK), .nRST(nRST),
    .in0__ENA(in0__ENA), .in0_v(in0_v), .in0__RDY(in0__RDY),
    .in1__ENA(in1__ENA), .in1_v(in1_v), .in1__RDY(in1__RDY),
    .deq__ENA(deq__ENA), .deq__RDY(deq__RDY),
    .first(first), .first_src(first_src), .first__RDY(first__RDY),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  // Same stimulus, 2-bit counters: exercises saturation alongside the main instance.
  l_class_oc_fifoarb2 #(.WIDTH(32), .CNTW(2)) u_sat (
    .CLK(CLK), .nRST(nRST),
    .in0__ENA(in0__ENA), .in0_v(in0_v), .in0__RDY(s_in0_rdy),
    .in1__ENA(in1__ENA), .in1_v(in1_v), .in1__RDY(s_in1_rdy),
    .deq__ENA(deq__ENA), .deq__RDY(s_deq_rdy),
    .first(s_first), .first_src(s_first_src), .first__RDY(s_first_rdy),
    .cnt0(s_cnt0), .cnt1(s_cnt1)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  bit          m_full;
  int          m_last;
  int          m_c0, m_c1;
  logic [31:0] m_data;
  bit          m_src;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat3(input int c);
    return (c > 3) ? 3 : c;
  endfunction

  task automatic model_reset();
    m_full = 1'b0; m_last = 1; m_c0 = 0; m_c1 = 0; m_data = '0; m_src = 1'b0;
  endtask

  task automatic check_state();
    chk("first_rdy", first__RDY, m_full);
    chk("first", first, m_data);
    chk("first_src", first_src, m_src);
    chk("cnt0", cnt0, 64'(m_c0));
    chk("cnt1", cnt1, 64'(m_c1));
    chk("sat_cnt0", s_cnt0, 64'(sat3(m_c0)));
    chk("sat_cnt1", s_cnt1, 64'(sat3(m_c1)));
  endtask

  // Called at a negedge; returns the requester the model expects granted (-1 for none).
  task automatic cycle(input bit e0, input logic [31:0] v0, input bit e1,
                       input logic [31:0] v1, input bit dq, output int g);
    in0__ENA = e0; in0_v = v0; in1__ENA = e1; in1_v = v1; deq__ENA = dq;
    #1;
    g = -1;
    if (!m_full) begin
      if (e0 && e1) g = 1 - m_last;
      else if (e0)  g = 0;
      else if (e1)  g = 1;
    end
    chk("in0_rdy", in0__RDY, g == 0);
    chk("in1_rdy", in1__RDY, g == 1);
    chk("deq_rdy", deq__RDY, m_full);
    @(posedge CLK);
    if (dq && m_full) m_full = 1'b0;
    if (g >= 0) begin
      m_full = 1'b1; m_last = g; m_src = (g == 1);
      m_data = (g == 0) ? v0 : v1;
      if (g == 0) m_c0++; else m_c1++;
    end
    @(negedge CLK);
    check_state();
  endtask

  task automatic do_reset();
    in0__ENA = 1'b1; in1__ENA = 1'b1; deq__ENA = 1'b0;
    #2 nRST = 1'b0;
    #1;
    chk("rst_first_rdy", first__RDY, 1'b0);
    chk("rst_deq_rdy", deq__RDY, 1'b0);
    chk("rst_in0_rdy", in0__RDY, 1'b0);
    chk("rst_in1_rdy", in1__RDY, 1'b0);
    chk("rst_cnt0", cnt0, 16'd0);
    chk("rst_cnt1", cnt1, 16'd0);
    chk("rst_first", first, 32'd0);
    model_reset();
    @(negedge CLK);
    in0__ENA = 1'b0; in1__ENA = 1'b0;
    nRST = 1'b1;
  endtask

  initial begin
    int g, k;
    bit p0, p1, dq;
    logic [31:0] v0, v1;
    int sat_exp[5] = '{1, 2, 3, 3, 3};

    model_reset();
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    check_state();

    // Single requester from reset.
    cycle(1'b1, 32'h12345678, 1'b0, 32'h0, 1'b0, g);
    chk("single_first", first, 32'h12345678);
    chk("single_cnt0", cnt0, 16'd1);
    cycle(1'b1, 32'h12345678, 1'b0, 32'h0, 1'b0, g);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, g);

    // deq while empty is ignored.
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, g);
    chk("ignored_deq_first", first, 32'h12345678);

    // Tie alternation from a fresh reset: 0,1,0,1.
    do_reset();
    k = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 32'hA, 1'b1, 32'hB, m_full, g);
      if (g >= 0) begin
        chk("alt_src", first_src, k % 2);
        k++;
      end
    end
    chk("alt_cnt0", cnt0, 16'd2);
    chk("alt_cnt1", cnt1, 16'd2);

    // Uncontested in1 then a tie: in0 wins.
    if (m_full) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, g);
    cycle(1'b0, 32'h0, 1'b1, 32'hC, 1'b0, g);
    chk("solo_src", first_src, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, g);
    cycle(1'b1, 32'hD, 1'b1, 32'hE, 1'b0, g);
    chk("tie_after_solo_src", first_src, 1'b0);
    chk("tie_after_solo_data", first, 32'hD);

    // Saturation of the 2-bit counter.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'(i), 1'b0, 32'h0, 1'b0, g);
      chk("sat_seq", s_cnt0, 64'(sat_exp[i]));
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, g);
    end

    // Random traffic; requesters hold ENA/data until granted.
    p0 = 0; p1 = 0; v0 = '0; v1 = '0;
    for (int i = 0; i < 300; i++) begin
      if (!p0) begin p0 = bit'($urandom_range(0, 1)); v0 = $urandom; end
      if (!p1) begin p1 = bit'($urandom_range(0, 1)); v1 = $urandom; end
      dq = ($urandom_range(0, 3) != 0);
      cycle(p0, v0, p1, v1, dq, g);
      if (g == 0) p0 = 0;
      if (g == 1) p1 = 0;
    end

    // Asynchronous reset mid-cycle while holding an entry.
    if (m_full) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, g);
    cycle(1'b1, 32'h55AA55AA, 1'b0, 32'h0, 1'b0, g);
    chk("pre_reset_full", first__RDY, 1'b1);
    do_reset();
    check_state();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
